// File: rtl/mmio_io_pkg.sv
// mmio_io_pkg
// Shared definitions for the memory-mapped I/O bridge:
//   - word offsets of the registers inside the 4 KiB I/O window
//   - CTRL register bit indices
//   - hex nibble to active-low 7-segment pattern conversion
package mmio_io_pkg;

  // Register offsets inside the I/O window.
  localparam logic [11:0] OFF_LED      = 12'h000;
  localparam logic [11:0] OFF_DIGITS   = 12'h004;
  localparam logic [11:0] OFF_DMASK    = 12'h008;
  localparam logic [11:0] OFF_SW       = 12'h00C;
  localparam logic [11:0] OFF_BTN      = 12'h010;
  localparam logic [11:0] OFF_BTN_EDGE = 12'h014;
  localparam logic [11:0] OFF_TIMER    = 12'h018;
  localparam logic [11:0] OFF_CTRL     = 12'h01C;

  // CTRL bits. Bit 1 is reserved and always reads 0.
  localparam int CTRL_TIMER_EN = 0;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is left off (1) here and
  // overridden by the caller.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One-bit button conditioner: 2-FF synchroniser followed by a
// consecutive-sample counter that flips the debounced level once the
// synchronised input has differed from it for DEB_CYCLES samples.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   raw_i   - raw asynchronous button input
//   level_o - debounced level (registered)
//   rise_o  - high in the cycle whose clock edge flips level 0->1
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic             meta_reg;
  logic             sync_reg;
  logic             level_reg;
  logic             level_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             flip;

  // The counter has already seen DEB_CYCLES-1 differing samples; this
  // one is the last needed.
  assign flip = (sync_reg != level_reg) && (cnt_reg == CNT_W'(DEB_CYCLES - 1));

  always_comb begin
    level_next = level_reg;
    cnt_next   = cnt_reg;
    if (sync_reg == level_reg) begin
      cnt_next = '0;
    end else if (flip) begin
      level_next = ~level_reg;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_reg  <= 1'b0;
      sync_reg  <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      meta_reg  <= raw_i;
      sync_reg  <= meta_reg;
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign level_o = level_reg;
  // Lets the edge register capture the rising edge on the same clock
  // edge that the level flips.
  assign rise_o  = flip & ~level_reg;

endmodule

// File: rtl/mmio_io_bridge.sv
// mmio_io_bridge
// Memory-mapped I/O bridge for a single-cycle core: decodes a 4 KiB
// window, serves combinational reads, holds LED / display / timer / CTRL
// registers, debounces buttons, synchronises switches and scans a
// multiplexed 7-segment display.
// Ports:
//   clk_i, rst_i         - clock, synchronous active-high reset
//   addr_i, we_i, wdata_i - CPU address, store strobe, store data
//   rdata_o, io_sel_o    - combinational read data, window hit
//   switches_i, buttons_i - raw asynchronous board inputs
//   leds_o               - registered LED state
//   digit_en_o, seg_o    - registered active-low digit enables / segments
module mmio_io_bridge
  import mmio_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F000,
  parameter int          LED_W      = 24,
  parameter int          SW_W       = 24,
  parameter int          BTN_W      = 5,
  parameter int          NUM_DIGITS = 8,
  parameter int          DEB_CYCLES = 16,
  parameter int          SCAN_DIV   = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  io_sel_o,
  input  logic [SW_W-1:0]       switches_i,
  input  logic [BTN_W-1:0]      buttons_i,
  output logic [LED_W-1:0]      leds_o,
  output logic [NUM_DIGITS-1:0] digit_en_o,
  output logic [7:0]            seg_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Address decode ---------------------------------------------------
  logic [11:0] word_off;
  logic        unused_addr;
  logic        wr_en;

  assign word_off    = {addr_i[11:2], 2'b00};
  assign unused_addr = ^addr_i[1:0];
  assign io_sel_o    = (addr_i[31:12] == BASE_ADDR[31:12]);
  assign wr_en       = we_i & io_sel_o;

  // Registers --------------------------------------------------------
  logic [LED_W-1:0]        led_reg,      led_next;
  logic [4*NUM_DIGITS-1:0] digits_reg,   digits_next;
  logic [NUM_DIGITS-1:0]   dmask_reg,    dmask_next;
  logic [NUM_DIGITS-1:0]   dp_reg,       dp_next;
  logic [31:0]             timer_reg,    timer_next;
  logic                    ctrl_en_reg,  ctrl_en_next;
  logic [BTN_W-1:0]        edge_reg,     edge_next;
  logic [SW_W-1:0]         sw_meta_reg,  sw_sync_reg;
  logic [DIV_W-1:0]        div_reg,      div_next;
  logic [IDX_W-1:0]        idx_reg,      idx_next;
  logic [NUM_DIGITS-1:0]   digit_en_reg, digit_en_next;
  logic [7:0]              seg_reg,      seg_next;

  logic [BTN_W-1:0] btn_level;
  logic [BTN_W-1:0] btn_rise;

  always_comb begin
    led_next     = led_reg;
    digits_next  = digits_reg;
    dmask_next   = dmask_reg;
    dp_next      = dp_reg;
    ctrl_en_next = ctrl_en_reg;
    timer_next   = timer_reg;

    if (wr_en && word_off == OFF_LED)    led_next    = wdata_i[LED_W-1:0];
    if (wr_en && word_off == OFF_DIGITS) digits_next = wdata_i[4*NUM_DIGITS-1:0];
    if (wr_en && word_off == OFF_DMASK) begin
      dmask_next = wdata_i[NUM_DIGITS-1:0];
      dp_next    = wdata_i[8 +: NUM_DIGITS];
    end
    if (wr_en && word_off == OFF_CTRL)   ctrl_en_next = wdata_i[CTRL_TIMER_EN];

    // A CPU store takes precedence over the free-running increment.
    if (wr_en && word_off == OFF_TIMER) begin
      timer_next = wdata_i;
    end else if (ctrl_en_reg) begin
      timer_next = timer_reg + 32'd1;
    end
  end

  // Buttons ----------------------------------------------------------
  for (genvar gi = 0; gi < BTN_W; gi++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .raw_i  (buttons_i[gi]),
      .level_o(btn_level[gi]),
      .rise_o (btn_rise[gi])
    );

    // A new rising edge beats a write-1-to-clear in the same cycle.
    assign edge_next[gi] = btn_rise[gi] |
                           (edge_reg[gi] & ~(wr_en && word_off == OFF_BTN_EDGE && wdata_i[gi]));
  end

  // Display scan -----------------------------------------------------
  always_comb begin
    div_next = div_reg + DIV_W'(1);
    idx_next = idx_reg;
    if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
      div_next = '0;
      idx_next = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  // Output refresh is continuous, so a changed DIGITS/DMASK shows up one
  // cycle later in the current slot.
  always_comb begin
    digit_en_next = '1;
    seg_next      = 8'hFF;
    if (dmask_reg[idx_reg]) begin
      digit_en_next[idx_reg] = 1'b0;
      seg_next               = hex_to_seg(digits_reg[{idx_reg, 2'b00} +: 4]);
      seg_next[7]            = ~dp_reg[idx_reg];
    end
  end

  // State ------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_reg      <= '0;
      digits_reg   <= '0;
      dmask_reg    <= '0;
      dp_reg       <= '0;
      timer_reg    <= '0;
      ctrl_en_reg  <= 1'b0;
      edge_reg     <= '0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      div_reg      <= '0;
      idx_reg      <= '0;
      digit_en_reg <= '1;
      seg_reg      <= 8'hFF;
    end else begin
      led_reg      <= led_next;
      digits_reg   <= digits_next;
      dmask_reg    <= dmask_next;
      dp_reg       <= dp_next;
      timer_reg    <= timer_next;
      ctrl_en_reg  <= ctrl_en_next;
      edge_reg     <= edge_next;
      sw_meta_reg  <= switches_i;
      sw_sync_reg  <= sw_meta_reg;
      div_reg      <= div_next;
      idx_reg      <= idx_next;
      digit_en_reg <= digit_en_next;
      seg_reg      <= seg_next;
    end
  end

  // Read mux ---------------------------------------------------------
  always_comb begin
    rdata_o = '0;
    if (io_sel_o) begin
      case (word_off)
        OFF_LED:      rdata_o[LED_W-1:0]        = led_reg;
        OFF_DIGITS:   rdata_o[4*NUM_DIGITS-1:0] = digits_reg;
        OFF_DMASK: begin
          rdata_o[NUM_DIGITS-1:0]  = dmask_reg;
          rdata_o[8 +: NUM_DIGITS] = dp_reg;
        end
        OFF_SW:       rdata_o[SW_W-1:0]         = sw_sync_reg;
        OFF_BTN:      rdata_o[BTN_W-1:0]        = btn_level;
        OFF_BTN_EDGE: rdata_o[BTN_W-1:0]        = edge_reg;
        OFF_TIMER:    rdata_o                   = timer_reg;
        OFF_CTRL:     rdata_o[CTRL_TIMER_EN]    = ctrl_en_reg;
        default:      rdata_o                   = '0;
      endcase
    end
  end

  assign leds_o     = led_reg;
  assign digit_en_o = digit_en_reg;
  assign seg_o      = seg_reg;

endmodule

// File: tb/tb_mmio_io_bridge.sv
module tb_mmio_io_bridge;

  localparam logic [31:0] B = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = B;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        io_sel;
  logic [23:0] switches = '0;
  logic [4:0]  buttons = '0;
  logic [23:0] leds;
  logic [7:0]  digit_en;
  logic [7:0]  seg;

  int total = 0;
  int bad = 0;

  // Segment patterns for DIGITS = 0x8765_4321, slot k shows k+1.
  logic [7:0] seg_tab [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};

  mmio_io_bridge #(
    .SCAN_DIV(4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .addr_i    (addr),
    .we_i      (we),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .io_sel_o  (io_sel),
    .switches_i(switches),
    .buttons_i (buttons),
    .leds_o    (leds),
    .digit_en_o(digit_en),
    .seg_o     (seg)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    addr  = B + off;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    $display("write off=%h data=%h", off, d);
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    addr = B + off;
    #1;
    d = rdata;
    $display("read  off=%h data=%h", off, d);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] offs [6] = '{32'h00, 32'h04, 32'h08, 32'h14, 32'h18, 32'h1C};
    repeat (3) @(posedge clk);
    #1;
    total++; if (leds !== 24'h0) begin bad++; $display("FAIL reset_leds got=%h want=000000", leds); end
    total++; if (digit_en !== 8'hFF) begin bad++; $display("FAIL reset_digit_en got=%h want=ff", digit_en); end
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", seg); end
    @(negedge clk);
    rst = 1'b0;
    foreach (offs[i]) begin
      rd(offs[i], v);
      total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_reg off=%h got=%h want=0", offs[i], v); end
    end
  endtask

  task automatic test_led_decode();
    logic [31:0] v;
    wr(32'h00, 32'h00A5_5A5A);
    total++; if (leds !== 24'hA55A5A) begin bad++; $display("FAIL led_out got=%h want=a55a5a", leds); end
    rd(32'h00, v);
    total++; if (v !== 32'h00A5_5A5A) begin bad++; $display("FAIL led_read got=%h want=00a55a5a", v); end
    rd(32'h02, v);
    total++; if (v !== 32'h00A5_5A5A) begin bad++; $display("FAIL led_read_lowbits got=%h want=00a55a5a", v); end
    wr(32'h00, 32'hFFFF_FFFF);
    rd(32'h00, v);
    total++; if (v !== 32'h00FF_FFFF) begin bad++; $display("FAIL led_width got=%h want=00ffffff", v); end
    wr(32'h20, 32'h1234_5678);
    rd(32'h20, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h want=0", v); end
    total++; if (leds !== 24'hFFFFFF) begin bad++; $display("FAIL unmapped_write got=%h want=ffffff", leds); end
    addr = 32'h0000_1000;
    #1;
    $display("decode addr=%h io_sel=%b rdata=%h", addr, io_sel, rdata);
    total++; if (io_sel !== 1'b0) begin bad++; $display("FAIL outside_sel got=%b want=0", io_sel); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL outside_rdata got=%h want=0", rdata); end
    addr = 32'hFFFF_EFFC;
    #1;
    total++; if (io_sel !== 1'b0) begin bad++; $display("FAIL below_base_sel got=%b want=0", io_sel); end
    addr = 32'hFFFF_FFFC;
    #1;
    total++; if (io_sel !== 1'b1) begin bad++; $display("FAIL top_of_window_sel got=%b want=1", io_sel); end
  endtask

  task automatic test_switches();
    logic [31:0] v;
    @(negedge clk);
    switches = 24'h123456;
    addr = B + 32'h0C;
    @(posedge clk); #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL sw_sync1 got=%h want=0", rdata); end
    @(posedge clk); #1;
    $display("switch read data=%h", rdata);
    total++; if (rdata !== 32'h0012_3456) begin bad++; $display("FAIL sw_sync2 got=%h want=00123456", rdata); end
    wr(32'h0C, 32'hFFFF_FFFF);
    rd(32'h0C, v);
    total++; if (v !== 32'h0012_3456) begin bad++; $display("FAIL sw_ro got=%h want=00123456", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    logic [31:0] seq [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    wr(32'h1C, 32'h3);
    rd(32'h1C, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL ctrl_read got=%h want=1", v); end
    wr(32'h18, 32'hFFFF_FFFE);
    foreach (seq[i]) begin
      if (i != 0) @(posedge clk);
      rd(32'h18, v);
      total++; if (v !== seq[i]) begin bad++; $display("FAIL timer_wrap step=%0d got=%h want=%h", i, v, seq[i]); end
    end
    wr(32'h18, 32'h10);
    rd(32'h18, v);
    total++; if (v !== 32'h10) begin bad++; $display("FAIL timer_write_wins got=%h want=10", v); end
    @(posedge clk);
    rd(32'h18, v);
    total++; if (v !== 32'h11) begin bad++; $display("FAIL timer_inc got=%h want=11", v); end
    wr(32'h1C, 32'h0);
    rd(32'h18, v);
    total++; if (v !== 32'h12) begin bad++; $display("FAIL timer_stop got=%h want=12", v); end
    @(posedge clk);
    rd(32'h18, v);
    total++; if (v !== 32'h12) begin bad++; $display("FAIL timer_hold got=%h want=12", v); end
  endtask

  task automatic test_buttons();
    logic [31:0] v;
    logic [31:0] exp;
    addr = B + 32'h10;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      buttons[0] = ((i / 3) % 2 == 0);
    end
    @(negedge clk);
    buttons[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      exp = (k == 18) ? 32'h1 : 32'h0;
      $display("btn hold k=%0d btn=%h", k, rdata);
      total++; if (rdata !== exp) begin bad++; $display("FAIL btn_level k=%0d got=%h want=%h", k, rdata, exp); end
    end
    rd(32'h14, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL btn_edge_set got=%h want=1", v); end
    wr(32'h14, 32'h1);
    rd(32'h14, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL btn_edge_clear got=%h want=0", v); end
    rd(32'h10, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL btn_level_held got=%h want=1", v); end
    @(negedge clk);
    buttons[0] = 1'b0;
    repeat (25) @(posedge clk);
    rd(32'h10, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL btn_release got=%h want=0", v); end
    rd(32'h14, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL btn_fall_no_edge got=%h want=0", v); end
    @(negedge clk);
    buttons[0] = 1'b1;
    repeat (17) @(posedge clk);
    rd(32'h10, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL btn_before_flip got=%h want=0", v); end
    wr(32'h14, 32'h1);
    rd(32'h14, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL btn_set_wins got=%h want=1", v); end
    rd(32'h10, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL btn_second_press got=%h want=1", v); end
  endtask

  task automatic test_scan();
    logic [7:0] exp_en;
    logic [7:0] exp_seg;
    int slot;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    addr  = B + 32'h04;
    wdata = 32'h8765_4321;
    we    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr  = B + 32'h08;
    wdata = 32'h0000_00FF;
    @(posedge clk); #1;
    we = 1'b0;
    total++; if (digit_en !== 8'hFF) begin bad++; $display("FAIL scan_premask got=%h want=ff", digit_en); end
    for (int n = 3; n <= 34; n++) begin
      @(posedge clk); #1;
      slot    = ((n - 1) / 4) % 8;
      exp_en  = ~(8'd1 << slot);
      exp_seg = seg_tab[slot];
      $display("scan n=%0d en=%h seg=%h", n, digit_en, seg);
      total++; if (digit_en !== exp_en) begin bad++; $display("FAIL scan_en n=%0d got=%h want=%h", n, digit_en, exp_en); end
      total++; if (seg !== exp_seg) begin bad++; $display("FAIL scan_seg n=%0d got=%h want=%h", n, seg, exp_seg); end
    end
    @(negedge clk);
    wdata = 32'h0000_0101;
    we    = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
    for (int n = 36; n <= 67; n++) begin
      @(posedge clk); #1;
      slot    = ((n - 1) / 4) % 8;
      exp_en  = (slot == 0) ? 8'hFE : 8'hFF;
      exp_seg = (slot == 0) ? 8'h79 : 8'hFF;
      $display("mask n=%0d en=%h seg=%h", n, digit_en, seg);
      total++; if (digit_en !== exp_en) begin bad++; $display("FAIL mask_en n=%0d got=%h want=%h", n, digit_en, exp_en); end
      total++; if (seg !== exp_seg) begin bad++; $display("FAIL mask_seg n=%0d got=%h want=%h", n, seg, exp_seg); end
    end
  endtask

  task automatic test_reset_midscan();
    logic [31:0] v;
    logic [7:0] exp_en [5] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFD};
    wr(32'h00, 32'h5A);
    wr(32'h1C, 32'h1);
    wr(32'h18, 32'h100);
    wr(32'h08, 32'hFF);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (leds !== 24'h0) begin bad++; $display("FAIL rst_leds got=%h want=0", leds); end
    total++; if (digit_en !== 8'hFF) begin bad++; $display("FAIL rst_en got=%h want=ff", digit_en); end
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL rst_seg got=%h want=ff", seg); end
    rd(32'h18, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_timer got=%h want=0", v); end
    rd(32'h1C, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h want=0", v); end
    rd(32'h00, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_led_reg got=%h want=0", v); end
    @(negedge clk);
    rst   = 1'b0;
    addr  = B + 32'h08;
    wdata = 32'hFF;
    we    = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      we = 1'b0;
      $display("restart e=%0d en=%h", e + 1, digit_en);
      total++; if (digit_en !== exp_en[e]) begin bad++; $display("FAIL restart_en e=%0d got=%h want=%h", e + 1, digit_en, exp_en[e]); end
    end
  endtask

  initial begin
    test_reset();
    test_led_decode();
    test_switches();
    test_timer();
    test_buttons();
    test_scan();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
